// File: rtl/lbr_unit_pkg.sv
// Shared encodings and register-window layout for the Last Branch Record unit.
package lbr_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } npc_sel_e;

    // 01 is treated exactly like idle; it is named so decode can stay exhaustive.
    typedef enum logic [1:0] {
        LBR_IDLE     = 2'b00,
        LBR_IDLE_ALT = 2'b01,
        LBR_READ     = 2'b10,
        LBR_WRITE    = 2'b11
    } lbr_req_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_FROM,
        SEL_TO,
        SEL_TOS,
        SEL_CTRL
    } win_sel_e;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    function automatic int tos_offset(input int depth);
        return 2 * depth;
    endfunction

    function automatic int ctrl_offset(input int depth);
        return 2 * depth + 1;
    endfunction

endpackage

// File: rtl/lbr_unit_ring_buffer.sv
// Circular from/to storage with its write pointer; recording overrides any
// same-cycle software write, and clear overrides everything.
module lbr_unit_ring_buffer
    import lbr_unit_pkg::*;
#(
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 8,
    parameter int IDX_W        = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    rec_en,
    input  logic [ADDRESS_BITS-1:0] rec_from,
    input  logic [ADDRESS_BITS-1:0] rec_to,
    input  logic                    wr_from_en,
    input  logic                    wr_to_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [ADDRESS_BITS-1:0] wr_data,
    input  logic                    tos_wr_en,
    input  logic [IDX_W-1:0]        tos_wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [ADDRESS_BITS-1:0] rd_from,
    output logic [ADDRESS_BITS-1:0] rd_to,
    output logic [IDX_W-1:0]        tos
);

    logic [ADDRESS_BITS-1:0] from_q [DEPTH];
    logic [ADDRESS_BITS-1:0] to_q   [DEPTH];

    // NOTE: the arrays live in flops, not a RAM macro, because reset and clear
    // must zero every entry in a single edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                from_q[i] <= '0;
                to_q[i]   <= '0;
            end
            tos <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                from_q[i] <= '0;
                to_q[i]   <= '0;
            end
            tos <= '0;
        end else begin
            if (wr_from_en) from_q[wr_idx] <= wr_data;
            if (wr_to_en)   to_q[wr_idx]   <= wr_data;
            if (tos_wr_en)  tos            <= tos_wr_data;
            // NOTE: with non-blocking assignments the last one to a target
            // wins, so placing the recording after the software write gives it
            // priority on a shared slot or on tos.
            if (rec_en) begin
                from_q[tos] <= rec_from;
                to_q[tos]   <= rec_to;
                tos         <= tos + 1'b1;
            end
        end
    end

    assign rd_from = from_q[rd_idx];
    assign rd_to   = to_q[rd_idx];

endmodule

// File: rtl/lbr_unit.sv
// Last Branch Record unit: records taken jumps into a ring buffer and exposes
// it through a word-indexed load/store window.
module lbr_unit
    import lbr_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH        = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [1:0]              lbrReq,
    input  logic [1:0]              next_PC_sel,
    input  logic [DATA_WIDTH-1:0]   RW_address,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    input  logic [ADDRESS_BITS-1:0] PC_address,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic [DATA_WIDTH-1:0]   output_data
);

    localparam int IDX_W       = $clog2(DEPTH);
    localparam int TOS_OFFSET  = tos_offset(DEPTH);
    localparam int CTRL_OFFSET = ctrl_offset(DEPTH);

    win_sel_e                win_sel;
    logic [IDX_W-1:0]        win_idx;
    logic                    enable;
    logic                    wr_req;
    logic                    rec_en;
    logic                    ctrl_wr;
    logic                    clear;
    logic [ADDRESS_BITS-1:0] rec_to;
    logic [ADDRESS_BITS-1:0] rd_from;
    logic [ADDRESS_BITS-1:0] rd_to;
    logic [IDX_W-1:0]        tos;

    // Full-width compares so large addresses never alias onto an entry.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        win_sel = SEL_NONE;
        if (RW_address < DATA_WIDTH'(DEPTH))
            win_sel = SEL_FROM;
        else if (RW_address < DATA_WIDTH'(TOS_OFFSET))
            win_sel = SEL_TO;
        else if (RW_address == DATA_WIDTH'(TOS_OFFSET))
            win_sel = SEL_TOS;
        else if (RW_address == DATA_WIDTH'(CTRL_OFFSET))
            win_sel = SEL_CTRL;
    end

    // DEPTH is a power of two, so A-DEPTH and A share their low index bits.
    assign win_idx = RW_address[IDX_W-1:0];

    assign wr_req  = (lbrReq == LBR_WRITE) && !stall;
    assign rec_en  = !stall && enable && next_PC_sel[1];
    assign rec_to  = (next_PC_sel == NPC_JAL) ? JAL_target : JALR_target;
    assign ctrl_wr = wr_req && (win_sel == SEL_CTRL);
    assign clear   = ctrl_wr && ALU_result[CTRL_CLEAR_BIT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            enable <= 1'b1;
        else if (ctrl_wr)
            enable <= ALU_result[CTRL_ENABLE_BIT];
    end

    lbr_unit_ring_buffer #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .DEPTH        (DEPTH),
        .IDX_W        (IDX_W)
    ) u_ring (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .rec_en      (rec_en),
        .rec_from    (PC_address),
        .rec_to      (rec_to),
        .wr_from_en  (wr_req && (win_sel == SEL_FROM)),
        .wr_to_en    (wr_req && (win_sel == SEL_TO)),
        .wr_idx      (win_idx),
        .wr_data     (ADDRESS_BITS'(ALU_result)),
        .tos_wr_en   (wr_req && (win_sel == SEL_TOS)),
        .tos_wr_data (ALU_result[IDX_W-1:0]),
        .rd_idx      (win_idx),
        .rd_from     (rd_from),
        .rd_to       (rd_to),
        .tos         (tos)
    );

    // Clear is write-only, so the control word reads back only the enable bit.
    always_comb begin
        output_data = '0;
        if (lbrReq == LBR_READ) begin
            case (win_sel)
                SEL_FROM: output_data = DATA_WIDTH'(rd_from);
                SEL_TO:   output_data = DATA_WIDTH'(rd_to);
                SEL_TOS:  output_data = DATA_WIDTH'(tos);
                SEL_CTRL: output_data = DATA_WIDTH'(enable);
                default:  output_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lbr_unit.sv
// Self-checking bench for lbr_unit (DEPTH=8, DATA=16, ADDR=12): every cycle
// queues the expected output_data, which is compared on the falling edge.
module tb_lbr_unit;
    import lbr_unit_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int DP = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic [1:0]    lbrReq = 2'b00;
    logic [1:0]    next_PC_sel = 2'b00;
    logic [DW-1:0] RW_address = '0;
    logic [DW-1:0] ALU_result = '0;
    logic [AW-1:0] PC_address = '0;
    logic [AW-1:0] JAL_target = '0;
    logic [AW-1:0] JALR_target = '0;
    logic [DW-1:0] output_data;

    lbr_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(DP)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .lbrReq      (lbrReq),
        .next_PC_sel (next_PC_sel),
        .RW_address  (RW_address),
        .ALU_result  (ALU_result),
        .PC_address  (PC_address),
        .JAL_target  (JAL_target),
        .JALR_target (JALR_target),
        .output_data (output_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] val;
        string         name;
    } exp_t;

    typedef struct {
        logic          st;
        logic [1:0]    npc;
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
    } jmp_vec_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] expv;
    } rd_vec_t;

    exp_t     exp_q[$];
    jmp_vec_t jmp_tab[8];
    rd_vec_t  rd_tab[32];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, output_data, e.val);
        end
    end

    // The unselected jump target gets the complement so a swapped mux shows up.
    task automatic step(input logic [1:0] req, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [1:0] npc, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                        input logic st, input logic [DW-1:0] expv, input string name);
        @(posedge clock);
        #1;
        lbrReq      = req;
        RW_address  = addr;
        ALU_result  = wdata;
        next_PC_sel = npc;
        PC_address  = pc;
        JAL_target  = (npc == NPC_JALR) ? ~tgt : tgt;
        JALR_target = (npc == NPC_JALR) ? tgt : ~tgt;
        stall       = st;
        exp_q.push_back('{val: expv, name: name});
    endtask

    task automatic rd(input logic [DW-1:0] addr, input logic [DW-1:0] expv, input string name);
        step(LBR_READ, addr, '0, NPC_PC4, '0, '0, 1'b0, expv, name);
    endtask

    task automatic wr(input logic [DW-1:0] addr, input logic [DW-1:0] data, input logic st, input string name);
        step(LBR_WRITE, addr, data, NPC_PC4, '0, '0, st, '0, name);
    endtask

    task automatic jmp(input logic [1:0] npc, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                       input logic st, input string name);
        step(LBR_IDLE, '0, '0, npc, pc, tgt, st, '0, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] from_exp[8];
        logic [AW-1:0] to_exp[8];
        from_exp = '{12'h000, 12'h001, 12'h002, 12'h004, 12'h005, 12'h006, 12'h007, 12'h000};
        to_exp   = '{12'hFFF, 12'h002, 12'h3FF, 12'h0FF, 12'h020, 12'h03F, 12'h080, 12'h000};
        for (int i = 0; i < 8; i++) begin
            jmp_tab[i].st  = (i == 3);
            jmp_tab[i].npc = (i % 2 == 0) ? NPC_JALR : NPC_JAL;
            jmp_tab[i].pc  = AW'(i);
            jmp_tab[i].tgt = (i % 2 == 0) ? (12'hFFF >> i) : (12'h001 << i);
        end
        for (int a = 0; a < 32; a++) begin
            rd_tab[a].addr = DW'(a);
            if (a < 8)        rd_tab[a].expv = DW'(from_exp[a]);
            else if (a < 16)  rd_tab[a].expv = DW'(to_exp[a-8]);
            else if (a == 16) rd_tab[a].expv = 16'd7;
            else if (a == 17) rd_tab[a].expv = 16'd1;
            else              rd_tab[a].expv = 16'd0;
        end

        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state of the whole window.
        for (int a = 0; a < 20; a++)
            rd(DW'(a), (a == 17) ? 16'd1 : 16'd0, $sformatf("reset_A%0d", a));

        // Eight jumps, one stalled; pre-edge reads during recording.
        for (int i = 0; i < 8; i++) begin
            if (i == 6)
                step(LBR_READ, 16'd5, '0, jmp_tab[i].npc, jmp_tab[i].pc, jmp_tab[i].tgt,
                     jmp_tab[i].st, 16'd0, "rd_slot_being_recorded");
            else if (i == 7)
                step(LBR_READ, 16'd16, '0, jmp_tab[i].npc, jmp_tab[i].pc, jmp_tab[i].tgt,
                     jmp_tab[i].st, 16'd6, "rd_tos_during_record");
            else
                jmp(jmp_tab[i].npc, jmp_tab[i].pc, jmp_tab[i].tgt, jmp_tab[i].st, $sformatf("jmp%0d", i));
        end
        for (int a = 0; a < 32; a++)
            rd(rd_tab[a].addr, rd_tab[a].expv, $sformatf("table_A%0d", a));

        // Wrap: slot 7 then slot 0.
        jmp(NPC_JAL, 12'h008, 12'h100, 1'b0, "jmp_wrap0");
        jmp(NPC_JALR, 12'h009, 12'h0AB, 1'b0, "jmp_wrap1");
        rd(16'd16, 16'd1, "wrap_tos");
        rd(16'd0, 16'h009, "wrap_from0");
        rd(16'd8, 16'h0AB, "wrap_to0");
        rd(16'd7, 16'h008, "wrap_from7");
        rd(16'd15, 16'h100, "wrap_to7");
        rd(16'd1, 16'h001, "wrap_from1_kept");

        // Software writes, stalled write, out-of-range writes.
        wr(16'd7, 16'hAAAA, 1'b0, "wr_from7");
        rd(16'd7, 16'h0AAA, "rd_from7_written");
        wr(16'd7, 16'h5555, 1'b1, "wr_from7_stalled");
        rd(16'd7, 16'h0AAA, "rd_from7_after_stall");
        wr(16'd15, 16'h1234, 1'b0, "wr_to7");
        rd(16'd15, 16'h0234, "rd_to7_written");
        wr(16'd18, 16'hFFFF, 1'b0, "wr_A18");
        wr(16'h8001, 16'hFFFF, 1'b0, "wr_A8001");
        rd(16'd18, 16'h0000, "rd_A18");
        rd(16'h8001, 16'h0000, "rd_A8001");
        rd(16'd1, 16'h0001, "rd_from1_no_alias");
        wr(16'd16, 16'hFFFD, 1'b0, "wr_tos");
        rd(16'd16, 16'd5, "rd_tos_written");

        // Recording beats a same-cycle software write to the slot and to tos.
        step(LBR_WRITE, 16'd5, 16'h0123, NPC_JAL, 12'h777, 12'h888, 1'b0, 16'd0, "wr_rec_slot");
        rd(16'd5, 16'h0777, "collide_from5");
        rd(16'd13, 16'h0888, "collide_to5");
        rd(16'd16, 16'd6, "collide_tos_a");
        step(LBR_WRITE, 16'd16, 16'h0002, NPC_JALR, 12'h010, 12'h020, 1'b0, 16'd0, "wr_rec_tos");
        rd(16'd16, 16'd7, "collide_tos_b");
        rd(16'd6, 16'h0010, "collide_from6");
        rd(16'd14, 16'h0020, "collide_to6");

        // Disabled recording.
        wr(16'd17, 16'h0000, 1'b0, "wr_ctrl_off");
        rd(16'd17, 16'd0, "rd_ctrl_off");
        jmp(NPC_JAL, 12'h0EE, 12'h0DD, 1'b0, "jmp_disabled0");
        jmp(NPC_JALR, 12'h0EF, 12'h0DE, 1'b0, "jmp_disabled1");
        rd(16'd16, 16'd7, "disabled_tos");
        rd(16'd7, 16'h0AAA, "disabled_from7");

        // Clear wins over a same-cycle recording.
        wr(16'd17, 16'h0001, 1'b0, "wr_ctrl_on");
        rd(16'd17, 16'd1, "rd_ctrl_on");
        step(LBR_WRITE, 16'd17, 16'h0003, NPC_JAL, 12'h0AB, 12'h0CD, 1'b0, 16'd0, "wr_clear_rec");
        for (int a = 0; a < 18; a++)
            rd(DW'(a), (a == 17) ? 16'd1 : 16'd0, $sformatf("cleared_A%0d", a));

        // Idle request codes read 0; branch and PC+4 never record.
        jmp(NPC_JAL, 12'h0AB, 12'h0CD, 1'b0, "jmp_after_clear");
        step(LBR_IDLE, 16'd0, '0, NPC_PC4, '0, '0, 1'b0, 16'd0, "idle00_A0");
        step(LBR_IDLE_ALT, 16'd0, '0, NPC_PC4, '0, '0, 1'b0, 16'd0, "idle01_A0");
        step(LBR_IDLE_ALT, 16'd8, '0, NPC_PC4, '0, '0, 1'b0, 16'd0, "idle01_A8");
        step(LBR_IDLE, 16'd17, '0, NPC_PC4, '0, '0, 1'b0, 16'd0, "idle00_A17");
        rd(16'd0, 16'h00AB, "rd_from0_new");
        rd(16'd8, 16'h00CD, "rd_to0_new");
        jmp(NPC_BRANCH, 12'h111, 12'h222, 1'b0, "jmp_branch");
        jmp(NPC_PC4, 12'h333, 12'h444, 1'b0, "jmp_pc4");
        rd(16'd16, 16'd1, "no_record_tos");
        rd(16'd1, 16'h0000, "no_record_from1");

        // Asynchronous reset mid-operation, then recording resumes.
        @(posedge clock);
        #2;
        reset = 1'b1;
        rd(16'd0, 16'h0000, "midreset_from0");
        rd(16'd16, 16'h0000, "midreset_tos");
        rd(16'd17, 16'h0001, "midreset_ctrl");
        @(negedge clock);
        reset = 1'b0;
        jmp(NPC_JAL, 12'h321, 12'h654, 1'b0, "jmp_after_reset");
        rd(16'd0, 16'h0321, "post_reset_from0");
        rd(16'd8, 16'h0654, "post_reset_to0");
        rd(16'd16, 16'd1, "post_reset_tos");

        repeat (2) @(negedge clock);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lbr_unit.md
Name: lbr_unit

Overview:
- Last Branch Record (LBR) unit for the BRISC-V core.
- Each time the core takes a jump, it captures the jump source PC and the jump target in a circular buffer of DEPTH entries.
- Software reads and writes the buffer through a small memory-mapped window driven by the core's load/store path (address from RW_address, write data from ALU_result).
- Sits beside the fetch/execute stages; purely observational, so it never stalls the core.

Parameters:
- DATA_WIDTH, 32, width of the load/store data path and of RW_address, ALU_result and output_data.
- ADDRESS_BITS, 20, width of PC and jump-target addresses.
- DEPTH, 8, number of LBR entries; must be a power of two and at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; when high, suppresses every state update.
- lbrReq  in  2  access request. 00 = idle; 10 = read; 11 = write; 01 = idle.
- next_PC_sel  in  2  fetch-mux select. 00 = PC+4; 01 = branch; 10 = JAL; 11 = JALR.
- RW_address  in  DATA_WIDTH  word index into the LBR register window.
- ALU_result  in  DATA_WIDTH  write data.
- PC_address  in  ADDRESS_BITS  PC of the instruction currently deciding next_PC_sel.
- JAL_target  in  ADDRESS_BITS  JAL destination.
- JALR_target  in  ADDRESS_BITS  JALR destination.
- output_data  out  DATA_WIDTH  read data.

Behaviour:
- Storage:
  - from[DEPTH] and to[DEPTH], each ADDRESS_BITS wide.
  - tos: log2(DEPTH)-bit write pointer.
  - enable: 1 bit.
- Reset (async): all from/to entries = 0, tos = 0, enable = 1. output_data is 0 while lbrReq is not 10.
- Recording, evaluated on the rising edge when !stall && enable && next_PC_sel[1]:
  - from[tos] <= PC_address.
  - to[tos] <= JAL_target if next_PC_sel == 10, else JALR_target.
  - tos <= tos + 1, wrapping from DEPTH-1 to 0. After a wrap the oldest entry is overwritten.
  - next_PC_sel values 00 and 01 never record.
- Register window, using word index A = RW_address:
  - A in 0..DEPTH-1: from[A].
  - A in DEPTH..2*DEPTH-1: to[A-DEPTH].
  - A = 2*DEPTH: tos.
  - A = 2*DEPTH+1: control. Bit0 = enable. Bit1 = clear: write-only, self-clearing, reads as 0.
  - Any other A: reads 0, writes ignored.
- Read:
  - Combinational. When lbrReq == 10, output_data = the selected field zero-extended to DATA_WIDTH; otherwise output_data = 0.
  - Reads are not gated by stall.
  - A read returns pre-edge contents, including an entry being recorded on the same edge.
- Write, on the rising edge when lbrReq == 11 && !stall:
  - Entry fields and tos take the low bits of ALU_result.
  - Control bit0 sets enable.
  - Control bit1 = 1 clears every entry and tos on that edge. The clear takes priority over a same-cycle recording.
- Simultaneous software write and recording to the same slot or to tos: recording wins.
- Any mid-operation reset restores the reset state immediately.

Decomposition:
- Shared package: next_PC_sel encodings (NPC_PC4, NPC_BRANCH, NPC_JAL, NPC_JALR), lbrReq encodings (LBR_IDLE, LBR_READ, LBR_WRITE), and window offset constants (TOS_OFFSET = 2*DEPTH, CTRL_OFFSET = 2*DEPTH+1).
- Optional sub-module lbr_ring_buffer holds the from/to arrays plus tos, with record, write and clear ports. The top level does address decode and the read mux.

Test Plan:
- Reset, then read A = 0..2*DEPTH+1 -> all 0 except control = 0x1.
- DEPTH=8, DATA=16, ADDR=12. For i = 0..7, PC = i; next_PC_sel = 11 (JALR, target 0xFFF>>i) on even i and 10 (JAL, target 1<<i) on odd i; stall high only during i=3. Then read A = 0..31 -> from[0..6] = 0,1,2,4,5,6,7; to[0..6] = FFF,002,3FF,0FF,020,03F,080; slot 7 = 0; A=16 reads 7; A=17 reads 1; A >= 18 reads 0.
- Continue with 2 more jumps -> tos wraps to 1 and slot 0 holds the newest record.
- Write A=7 with 0xAAAA (lbrReq = 11) -> from[7] reads 0xAAA. Repeat the write with stall high -> unchanged.
- Write control = 0x0, then issue JALs -> nothing recorded. Write control = 0x3 -> all entries and tos read 0, enable = 1.
- lbrReq = 00 or 01 with any address -> output_data = 0; next_PC_sel = 01 -> no record.
